// File: rtl/inst_queue.sv
// inst_queue: circular instruction FIFO between the fetch and decode stages.
// Latency: 1 cycle from push to iq_to_ds_valid (0 cycles with INST_QUEUE_BYPASS_EN on an empty queue).
// Backpressure: iq_allowin = not full, registered only; decode holds the head with ds_allowin=0.
//
// Optional feature macro: INST_QUEUE_BYPASS_EN (empty-queue combinational bypass).
//
// Ports:
//   clk, resetn          - rising-edge clock, asynchronous active-low reset
//   fs_to_iq_valid/_bus  - fetch offers one instruction (opaque payload)
//   iq_allowin           - queue accepts a push this cycle (feeds fetch's ds_allowin)
//   iq_to_ds_valid/_bus  - head entry presented to decode
//   ds_allowin           - decode takes the head this cycle
//   flush, br_flush      - either one empties the queue at the next edge
//   iq_count             - number of occupied entries
module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = 109,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fs_to_iq_valid,
  input  logic [BUS_WD-1:0] fs_to_iq_bus,
  output logic              iq_allowin,
  output logic              iq_to_ds_valid,
  output logic [BUS_WD-1:0] iq_to_ds_bus,
  input  logic              ds_allowin,
  input  logic              flush,
  input  logic              br_flush,
  output logic [AW:0]       iq_count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [BUS_WD-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_count;

  logic w_flush;
  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;

  // Both flush sources act identically; asserting both is one flush.
  assign w_flush = flush | br_flush;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue: fetch is shown straight to decode. If decode takes it
  // this cycle the instruction never touches storage.
  assign w_bypass       = w_empty & fs_to_iq_valid & ds_allowin & ~w_flush;
  assign iq_to_ds_valid = w_empty ? fs_to_iq_valid : 1'b1;
  assign iq_to_ds_bus   = w_empty ? fs_to_iq_bus : r_mem[r_rd_ptr];
`else
  assign w_bypass       = 1'b0;
  assign iq_to_ds_valid = ~w_empty;
  assign iq_to_ds_bus   = r_mem[r_rd_ptr];
`endif

  // allowin depends only on the registered count, so a full queue refuses
  // a push even when decode pops in the same cycle.
  assign iq_allowin = ~w_full;
  assign iq_count   = r_count;

  assign w_push = fs_to_iq_valid & ~w_full & ~w_flush & ~w_bypass;
  // Pop only from storage; a bypassed instruction is not an entry.
  assign w_pop  = ~w_empty & ds_allowin & ~w_flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; its contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= fs_to_iq_bus;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed bench for inst_queue with a queue-based scoreboard.
// Every cycle compares valid/allowin/count and the head payload against the model.
// Expected payloads are pushed when an accepted push is driven and popped on a take.
module tb_inst_queue;

  localparam int DEPTH  = 4;
  localparam int BUS_WD = 109;
  localparam int AW     = $clog2(DEPTH);
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              resetn;
  logic              fs_to_iq_valid;
  logic [BUS_WD-1:0] fs_to_iq_bus;
  logic              iq_allowin;
  logic              iq_to_ds_valid;
  logic [BUS_WD-1:0] iq_to_ds_bus;
  logic              ds_allowin;
  logic              flush;
  logic              br_flush;
  logic [AW:0]       iq_count;

  inst_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .fs_to_iq_valid (fs_to_iq_valid),
    .fs_to_iq_bus   (fs_to_iq_bus),
    .iq_allowin     (iq_allowin),
    .iq_to_ds_valid (iq_to_ds_valid),
    .iq_to_ds_bus   (iq_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .flush          (flush),
    .br_flush       (br_flush),
    .iq_count       (iq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int mcnt    = 0;
  logic [BUS_WD-1:0] sb [$];

  function automatic logic [BUS_WD-1:0] mkpay(input logic [31:0] pc);
    return {13'h0, pc ^ 32'h5a5a_0000, ~pc, pc};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive, compare against the model, advance model and clock.
  task automatic step(input logic fv, input logic [31:0] pc, input logic ds,
                      input logic fl, input logic bfl);
    logic [BUS_WD-1:0] pay;
    bit f, byp, push, pop, ev;
    pay = mkpay(pc);
    fs_to_iq_valid = fv;
    fs_to_iq_bus   = pay;
    ds_allowin     = ds;
    flush          = fl;
    br_flush       = bfl;
    #1;
    f  = fl | bfl;
    ev = (BYP && mcnt == 0) ? fv : (mcnt != 0);
    check("valid", iq_to_ds_valid, ev);
    check("allowin", iq_allowin, mcnt != DEPTH);
    check("count", iq_count, mcnt);
    if (mcnt != 0) check("head_bus", iq_to_ds_bus, sb[0]);
    else if (BYP && fv) check("bypass_bus", iq_to_ds_bus, pay);
    byp  = BYP && mcnt == 0 && fv && ds && !f;
    push = fv && mcnt != DEPTH && !f && !byp;
    pop  = mcnt != 0 && ds && !f;
    if (pop) sb.delete(0);
    if (push) sb.push_back(pay);
    if (f) begin
      mcnt = 0;
      sb.delete();
    end else begin
      mcnt = mcnt + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn         = 1'b0;
    fs_to_iq_valid = 1'b0;
    fs_to_iq_bus   = '0;
    ds_allowin     = 1'b0;
    flush          = 1'b0;
    br_flush       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset state.
    check("rst_valid", iq_to_ds_valid, 1'b0);
    check("rst_allowin", iq_allowin, 1'b1);
    check("rst_count", iq_count, 0);
    resetn = 1'b1;

    // Fill with decode stalled; the fifth offer is refused and never seen.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h1c00_0000 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1c00_00f0, 1'b0, 1'b0, 1'b0);
    check("full_count", iq_count, 4);
    check("full_allowin", iq_allowin, 1'b0);

    // Push and pop held together from full: head order 00,04,08,0c then new.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h1c00_0010 + 32'(4*i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Three entries, then flush with a concurrent offer.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h1c00_0020 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1c00_dead, 1'b0, 1'b1, 1'b0);
    check("flush_count", iq_count, 0);
    check("flush_valid", iq_to_ds_valid, 1'b0);

    // br_flush with a pop attempted (and both flushes together once).
    for (int i = 0; i < 2; i++) step(1'b1, 32'h1c00_0030 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("brflush_count", iq_count, 0);
    step(1'b1, 32'h1c00_0100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1c00_0104, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1c00_0108, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h1c00_0100, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Seven pushes and seven pops interleaved across pointer wrap.
    for (int i = 0; i < 7; i++) step(1'b1, 32'h1c00_0200 + 32'(4*i), i >= 2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++)
      step(i % 3 != 2, 32'h1c00_0300 + 32'(4*i), (i % 2) == 1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 2; i++) step(1'b1, 32'h1c00_0400 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_count", iq_count, 0);
    check("arst_valid", iq_to_ds_valid, 1'b0);
    check("arst_allowin", iq_allowin, 1'b1);
    mcnt = 0;
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(1'b1, 32'h1c00_0500, 1'b0, 1'b0, 1'b0);
    check("post_rst_count", iq_count, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Empty queue, push with decode ready: bypass shows it at once, else one cycle later.
    step(1'b1, 32'h1c00_0040, 1'b1, 1'b0, 1'b0);
    check("byp_next_count", iq_count, BYP ? 0 : 1);
    check("byp_next_valid", iq_to_ds_valid, !BYP);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
